hazard_stall_controller: RTL
============================

// Module: hazard_stall_controller
// PURPOSE
//  Sequences pipeline stalls, bubbles and flushes for the 5-stage MIPS pipeline.
//  Drives the sel input of the control-signal bubble mux (ctrl_sel), the PC and IF/ID write enables,
//  the IF/ID flush and a global freeze for multicycle data-memory access.
//  Holds multi-cycle load-use stalls and memory waits in a small FSM, and counts stall and flush cycles.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..3)
//  CNT_W              16  width of the stall and flush counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  id_ex_mem_read in   1      instruction in EX is a load
//  id_ex_rt       in   5      destination register of the load in EX
//  if_id_rs       in   5      rs of the instruction in ID
//  if_id_rt       in   5      rt of the instruction in ID
//  if_id_uses_rt  in   1      instruction in ID reads rt (R-type, sw, beq)
//  branch_taken   in   1      branch/jump resolved taken in ID this cycle
//  mem_busy       in   1      data memory not ready; the whole pipeline must freeze
//  pc_write       out  1      PC load enable
//  if_id_write    out  1      IF/ID register load enable
//  if_id_flush    out  1      clear IF/ID (wrong-path instruction)
//  ctrl_sel       out  1      1 = pass ID control signals; 0 = inject bubble (all controls 0)
//  pipe_en        out  1      enable for ID/EX, EX/MEM and MEM/WB registers
//  stall_cnt      out  CNT_W  cycles with pc_write=0 since reset, saturating
//  flush_cnt      out  CNT_W  cycles with if_id_flush=1 since reset, saturating
// BEHAVIOUR
//  lu_hit = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
//  States: RUN, STALL, MEM_WAIT. Registers: state, ret_state, rem (2 bits), stall_cnt, flush_cnt.
//  Reset (rst=1 at an edge): state=RUN, ret_state=RUN, rem=0, counters=0.
//  While rst=1, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=0, ctrl_sel=0, pipe_en=0.
//  Outputs are combinational from state and inputs. Priority is mem_busy > stall > lu_hit > branch_taken.
//  RUN, mem_busy=1:
//   - freeze: pc_write=0, if_id_write=0, pipe_en=0, ctrl_sel=1, flush=0.
//   - next state MEM_WAIT, ret_state=RUN.
//  RUN, lu_hit=1:
//   - bubble: pc_write=0, if_id_write=0, ctrl_sel=0, pipe_en=1, flush=0. branch_taken is ignored.
//   - if LOAD_STALL_CYCLES=1, stay in RUN.
//   - otherwise go to STALL with rem=LOAD_STALL_CYCLES-2.
//  RUN, branch_taken=1 (no hazard): pc_write=1, if_id_write=1, if_id_flush=1, ctrl_sel=1, pipe_en=1.
//  RUN, idle: pc_write=1, if_id_write=1, ctrl_sel=1, pipe_en=1, flush=0.
//  STALL, mem_busy=0:
//   - same outputs as a lu_hit bubble. lu_hit and branch_taken are ignored.
//   - if rem=0, go to RUN; otherwise rem decrements.
//  STALL, mem_busy=1:
//   - freeze outputs as in MEM_WAIT; rem is held.
//   - next state MEM_WAIT, ret_state=STALL.
//  MEM_WAIT: freeze outputs while mem_busy=1.
//   - on the first cycle with mem_busy=0, state returns to ret_state.
//   - that cycle's outputs are evaluated as if already in ret_state, with mem_busy=0.
//  Counters, at each edge with rst=0:
//   - stall_cnt += 1 if pc_write=0; flush_cnt += 1 if if_id_flush=1.
//   - both hold at 2^CNT_W-1.
//  Latency: bubble and flush are same-cycle (combinational); state changes take effect at the next edge.
// TESTING
//  1 Reset: rst=1 for 2 cycles, inputs random -> all outputs 0; after release with no hazard, pc_write=1, ctrl_sel=1, counters=0.
//  2 Load-use, LOAD_STALL_CYCLES=1: lw $t0 in EX, ID reads rs=$t0 -> one cycle with ctrl_sel=0, pc_write=0; next cycle RUN; stall_cnt=1.
//  3 LOAD_STALL_CYCLES=3, id_ex_rt=5=if_id_rt, if_id_uses_rt=1 -> exactly 3 consecutive bubble cycles; id_ex_rt=0 -> no stall.
//  4 branch_taken pulse for 1 cycle in RUN -> if_id_flush=1 that cycle only, pc_write=1; flush_cnt=1.
//  5 mem_busy=1 for 4 cycles in the 2nd STALL cycle (LOAD_STALL_CYCLES=3) -> pipe_en=0 for 4 cycles, then 2 further bubbles, then RUN.
//  6 CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3; rst mid-STALL -> RUN with no residual bubble.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// branch flushes and whole-pipe freeze on data-memory waits, with saturating event counters.
module hazard_stall_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             ctrl_sel,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_STALL    = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    localparam logic [1:0] REM_INIT =
        (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ret_state_q, ret_state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       eff_state;
    logic             lu_hit;

    always_comb begin
        lu_hit = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

        // Leaving MEM_WAIT behaves exactly like the state we are returning to.
        eff_state = ((state_q == S_MEM_WAIT) && !mem_busy) ? ret_state_q : state_q;

        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        ctrl_sel    = 1'b0;
        pipe_en     = 1'b0;
        state_d     = state_q;
        ret_state_d = ret_state_q;
        rem_d       = rem_q;

        if (mem_busy) begin
            ctrl_sel = 1'b1;
            state_d  = S_MEM_WAIT;
            if (state_q == S_RUN) begin
                ret_state_d = S_RUN;
            end else if (state_q == S_STALL) begin
                ret_state_d = S_STALL;
            end
        end else if (eff_state == S_STALL) begin
            pipe_en = 1'b1;
            if (rem_q == 2'd0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_STALL;
                rem_d   = rem_q - 2'd1;
            end
        end else begin
            state_d = S_RUN;
            if (lu_hit) begin
                pipe_en = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = S_STALL;
                    rem_d   = REM_INIT;
                end
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = branch_taken;
                ctrl_sel    = 1'b1;
                pipe_en     = 1'b1;
            end
        end

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            ctrl_sel    = 1'b0;
            pipe_en     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            ret_state_q <= S_RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
